// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back sequencer:
//   - MemtoReg source code constants (the mux input numbering)
//   - default timing/legality parameters
//   - FSM state encoding
//   - is_legal_src(): source-code legality check used at request acceptance
// -----------------------------------------------------------------------------
package wb_pkg;

    // MemtoReg mux input numbering
    localparam logic [3:0] SRC_ALUOUT   = 4'd0;
    localparam logic [3:0] SRC_MDR      = 4'd1;
    localparam logic [3:0] SRC_CONST227 = 4'd2;
    localparam logic [3:0] SRC_3        = 4'd3;
    localparam logic [3:0] SRC_4        = 4'd4;
    localparam logic [3:0] SRC_5        = 4'd5;
    localparam logic [3:0] SRC_6        = 4'd6;
    localparam logic [3:0] SRC_RSVD     = 4'd7;
    localparam logic [3:0] SRC_8        = 4'd8;

    // Defaults for the wb_ctrl parameters
    localparam int         MEM_WAIT_DEF = 2;
    localparam logic [3:0] MEM_SRC_DEF  = SRC_MDR;
    localparam logic [3:0] MAX_SRC_DEF  = SRC_8;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } wb_state_e;

    // Code 7 is a hole in the mux numbering; anything above max_src has no mux input.
    function automatic logic is_legal_src(input logic [3:0] src, input logic [3:0] max_src);
        return (src != SRC_RSVD) && (src <= max_src);
    endfunction

endpackage

// File: rtl/wb_wait_cnt.sv
// -----------------------------------------------------------------------------
// wb_wait_cnt
// Loadable down-counter that times the memory latency of load write-backs.
// Saturates at zero; zero flag is decoded from the count register.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset (count -> 0)
//   clr       in   synchronous clear (count -> 0), used on squash
//   load      in   load load_val (wins over dec)
//   load_val  in   value to load [W-1:0]
//   dec       in   decrement by one when non-zero
//   zero      out  count register equals zero
// -----------------------------------------------------------------------------
module wb_wait_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next-count selection: clear, load, decrement (saturating) or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/wb_ctrl.sv
// -----------------------------------------------------------------------------
// wb_ctrl
// Write-back sequencer in front of the MemtoReg mux and the register bank.
// Takes one request at a time, waits out load latency for the memory source,
// then raises RegWrite for exactly one cycle. All outputs are registered.
//
// Parameters:
//   MEM_WAIT  cycles from acceptance until load data is valid at mux input 1
//   MEM_SRC   source code that needs the MEM_WAIT delay
//   MAX_SRC   highest legal source code (7 is always illegal)
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wb_valid/wb_ready     request handshake (ready only in IDLE)
//   wb_src, wb_dst        request payload, latched at acceptance
//   flush                 squash pending write-back / block acceptance
//   MemtoReg, WriteReg    latched select and address, held until next accept
//   RegWrite              one-cycle write enable (suppressed for $0)
//   wb_done               one-cycle pulse when a request retires
//   wb_err                one-cycle pulse when an illegal source is rejected
// Optional build macro WB_PENDING_EN adds pend_valid/pend_reg, which flag the
// in-flight destination register so the decoder can stall on RAW hazards.
// -----------------------------------------------------------------------------
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int         MEM_WAIT = MEM_WAIT_DEF,
    parameter logic [3:0] MEM_SRC  = MEM_SRC_DEF,
    parameter logic [3:0] MAX_SRC  = MAX_SRC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_valid,
    output logic       wb_ready,
    input  logic [3:0] wb_src,
    input  logic [4:0] wb_dst,
    input  logic       flush,
    output logic [3:0] MemtoReg,
    output logic       RegWrite,
    output logic [4:0] WriteReg,
    output logic       wb_done,
    output logic       wb_err
`ifdef WB_PENDING_EN
    ,
    output logic       pend_valid,
    output logic [4:0] pend_reg
`endif
);

    // Counter sized for MEM_WAIT-1; at least one bit so MEM_WAIT of 0/1 still elaborates.
    localparam int            CW       = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = (MEM_WAIT > 0) ? CW'(MEM_WAIT - 1) : {CW{1'b0}};
    localparam logic          HAS_WAIT = (MEM_WAIT > 0);

    wb_state_e  state_d,     state_q;
    logic [3:0] memto_reg_d, memto_reg_q;
    logic [4:0] write_reg_d, write_reg_q;
    logic       reg_write_d, reg_write_q;
    logic       wb_done_d,   wb_done_q;
    logic       wb_err_d,    wb_err_q;
    logic       wb_ready_d,  wb_ready_q;
`ifdef WB_PENDING_EN
    logic       pend_valid_d, pend_valid_q;
`endif

    logic       cnt_load_s;
    logic       cnt_dec_s;
    logic       cnt_zero_s;

    wb_wait_cnt #(
        .W (CW)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (flush),
        .load     (cnt_load_s),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Next-state and next-output decode. Outputs are computed for the state being
    // entered, so RegWrite/wb_done are high during the WRITE cycle itself.
    always_comb begin
        state_d     = state_q;
        memto_reg_d = memto_reg_q;
        write_reg_d = write_reg_q;
        reg_write_d = 1'b0;
        wb_done_d   = 1'b0;
        wb_err_d    = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;

        case (state_q)
            IDLE: begin
                // flush in IDLE blocks acceptance for this edge
                if (flush) begin
                    state_d = IDLE;
                end else if (wb_valid && wb_ready_q) begin
                    if (!is_legal_src(wb_src, MAX_SRC)) begin
                        // rejected: latched select/address are left untouched
                        wb_err_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        memto_reg_d = wb_src;
                        write_reg_d = wb_dst;
                        if (HAS_WAIT && (wb_src == MEM_SRC)) begin
                            state_d    = WAIT;
                            cnt_load_s = 1'b1;
                        end else begin
                            state_d     = WRITE;
                            reg_write_d = (wb_dst != 5'd0);
                            wb_done_d   = 1'b1;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                // a flush seen here is the last chance to squash before RegWrite rises
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_zero_s) begin
                    state_d     = WRITE;
                    reg_write_d = (write_reg_q != 5'd0);
                    wb_done_d   = 1'b1;
                end else begin
                    state_d   = WAIT;
                    cnt_dec_s = 1'b1;
                end
            end
            WRITE: begin
                // the write already happened this cycle; flush or not, we return to IDLE
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wb_ready_d = (state_d == IDLE);
`ifdef WB_PENDING_EN
        pend_valid_d = (state_d != IDLE);
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            memto_reg_q <= 4'd0;
            write_reg_q <= 5'd0;
            reg_write_q <= 1'b0;
            wb_done_q   <= 1'b0;
            wb_err_q    <= 1'b0;
            wb_ready_q  <= 1'b1;
`ifdef WB_PENDING_EN
            pend_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            memto_reg_q <= memto_reg_d;
            write_reg_q <= write_reg_d;
            reg_write_q <= reg_write_d;
            wb_done_q   <= wb_done_d;
            wb_err_q    <= wb_err_d;
            wb_ready_q  <= wb_ready_d;
`ifdef WB_PENDING_EN
            pend_valid_q <= pend_valid_d;
`endif
        end
    end

    assign wb_ready = wb_ready_q;
    assign MemtoReg = memto_reg_q;
    assign WriteReg = write_reg_q;
    assign RegWrite = reg_write_q;
    assign wb_done  = wb_done_q;
    assign wb_err   = wb_err_q;
`ifdef WB_PENDING_EN
    assign pend_valid = pend_valid_q;
    assign pend_reg   = write_reg_q;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_ctrl
// Self-checking bench for wb_ctrl (default parameters: MEM_WAIT=2, MEM_SRC=1,
// MAX_SRC=8). Table of requests with hand-derived expectations, a scoreboard
// queue, and hand-written sequences for reset, flush and back-to-back cases.
// -----------------------------------------------------------------------------
module tb_wb_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wb_valid;
    logic       wb_ready;
    logic [3:0] wb_src;
    logic [4:0] wb_dst;
    logic       flush;
    logic [3:0] MemtoReg;
    logic       RegWrite;
    logic [4:0] WriteReg;
    logic       wb_done;
    logic       wb_err;
`ifdef WB_PENDING_EN
    logic       pend_valid;
    logic [4:0] pend_reg;
`endif

    wb_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_src   (wb_src),
        .wb_dst   (wb_dst),
        .flush    (flush),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .WriteReg (WriteReg),
        .wb_done  (wb_done),
        .wb_err   (wb_err)
`ifdef WB_PENDING_EN
        ,
        .pend_valid (pend_valid),
        .pend_reg   (pend_reg)
`endif
    );

    always #5 clk = ~clk;

    // Request record: inputs plus expected behaviour
    typedef struct {
        logic [3:0] src;
        logic [4:0] dst;
        logic       err;  // rejected as illegal
        logic       we;   // RegWrite expected in the write cycle
        int         lat;  // cycles after accept edge until the write cycle
    } vec_t;

    vec_t       vecs [8];
    vec_t       sb_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] m_memto;  // model of latched MemtoReg
    logic [4:0] m_wreg;   // model of latched WriteReg

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".RegWrite"}, {31'd0, RegWrite}, 32'd0);
        check({tag, ".wb_done"},  {31'd0, wb_done},  32'd0);
        check({tag, ".wb_err"},   {31'd0, wb_err},   32'd0);
        check({tag, ".wb_ready"}, {31'd0, wb_ready}, 32'd1);
        check({tag, ".MemtoReg"}, {28'd0, MemtoReg}, {28'd0, m_memto});
        check({tag, ".WriteReg"}, {27'd0, WriteReg}, {27'd0, m_wreg});
    endtask

    // Drive one request, push its expectation, then pop and check it cycle by cycle
    task automatic apply_vec(input vec_t v);
        vec_t e;
        @(negedge clk);
        wb_valid = 1'b1;
        wb_src   = v.src;
        wb_dst   = v.dst;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        // scramble payload after acceptance: must be ignored
        wb_valid = 1'b0;
        wb_src   = 4'($urandom_range(15, 0));
        wb_dst   = 5'($urandom_range(31, 0));
        e = sb_q.pop_front();
        if (!e.err) begin
            m_memto = e.src;
            m_wreg  = e.dst;
        end
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("vec src%0d dst%0d k%0d RegWrite", e.src, e.dst, k),
                  {31'd0, RegWrite}, {31'd0, (!e.err && e.we && (k == e.lat))});
            check($sformatf("vec src%0d dst%0d k%0d wb_done", e.src, e.dst, k),
                  {31'd0, wb_done}, {31'd0, (!e.err && (k == e.lat))});
            check($sformatf("vec src%0d dst%0d k%0d wb_err", e.src, e.dst, k),
                  {31'd0, wb_err}, {31'd0, (e.err && (k == 1))});
            check($sformatf("vec src%0d dst%0d k%0d wb_ready", e.src, e.dst, k),
                  {31'd0, wb_ready}, {31'd0, (e.err || (k > e.lat))});
            check($sformatf("vec src%0d dst%0d k%0d MemtoReg", e.src, e.dst, k),
                  {28'd0, MemtoReg}, {28'd0, m_memto});
            check($sformatf("vec src%0d dst%0d k%0d WriteReg", e.src, e.dst, k),
                  {27'd0, WriteReg}, {27'd0, m_wreg});
`ifdef WB_PENDING_EN
            check($sformatf("vec src%0d dst%0d k%0d pend_valid", e.src, e.dst, k),
                  {31'd0, pend_valid}, {31'd0, (!e.err && (k <= e.lat))});
            if (!e.err && (k <= e.lat)) begin
                check($sformatf("vec src%0d dst%0d k%0d pend_reg", e.src, e.dst, k),
                      {27'd0, pend_reg}, {27'd0, e.dst});
            end else begin
                check($sformatf("vec src%0d dst%0d k%0d pend_reg_idle", e.src, e.dst, k),
                      {31'd0, pend_valid}, 32'd0);
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // src, dst, err, we, lat  (MEM_WAIT=2 -> memory source writes 3 cycles after accept)
        vecs[0] = '{4'd0, 5'd5,  1'b0, 1'b1, 1};
        vecs[1] = '{4'd1, 5'd9,  1'b0, 1'b1, 3};
        vecs[2] = '{4'd7, 5'd3,  1'b1, 1'b0, 0};
        vecs[3] = '{4'd9, 5'd4,  1'b1, 1'b0, 0};
        vecs[4] = '{4'd2, 5'd0,  1'b0, 1'b0, 1};
        vecs[5] = '{4'd8, 5'd31, 1'b0, 1'b1, 1};
        vecs[6] = '{4'd15, 5'd1, 1'b1, 1'b0, 0};
        vecs[7] = '{4'd1, 5'd0,  1'b0, 1'b0, 3};

        // ---- reset with a valid request present: nothing accepted ----
        reset    = 1'b1;
        wb_valid = 1'b1;
        wb_src   = 4'd0;
        wb_dst   = 5'd5;
        flush    = 1'b0;
        m_memto  = 4'd0;
        m_wreg   = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset    = 1'b0;
        wb_valid = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("post_reset");

        // ---- table-driven requests ----
        for (int i = 0; i < 8; i++) begin
            apply_vec(vecs[i]);
        end

        // ---- flush in IDLE blocks acceptance ----
        @(negedge clk);
        wb_valid = 1'b1;
        wb_src   = 4'd0;
        wb_dst   = 5'd20;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        flush    = 1'b0;
        check_idle_outputs("flush_idle");

        // ---- load request squashed in WAIT, then a normal request ----
        @(negedge clk);
        wb_valid = 1'b1;
        wb_src   = 4'd1;
        wb_dst   = 5'd4;
        @(posedge clk);              // accept edge N
        #1;
        wb_valid = 1'b0;
        m_memto  = 4'd1;
        m_wreg   = 5'd4;
        check("flush_wait.ready_n1", {31'd0, wb_ready}, 32'd0);
        @(posedge clk);              // into cycle N+2
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);              // flush sampled at end of N+2
        #1;
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_idle_outputs($sformatf("flush_wait_c%0d", k));
`ifdef WB_PENDING_EN
            check($sformatf("flush_wait_c%0d.pend_valid", k), {31'd0, pend_valid}, 32'd0);
`endif
            @(posedge clk);
            #1;
        end
        apply_vec('{4'd3, 5'd6, 1'b0, 1'b1, 1});

        // ---- back-to-back: second request held valid, accepted once IDLE ----
        @(negedge clk);
        wb_valid = 1'b1;
        wb_src   = 4'd0;
        wb_dst   = 5'd7;
        @(posedge clk);              // accept edge N
        #1;
        wb_src   = 4'd4;
        wb_dst   = 5'd8;
        check("b2b.first_we",  {31'd0, RegWrite}, 32'd1);
        check("b2b.first_wr",  {27'd0, WriteReg}, 32'd7);
        check("b2b.ready_n1",  {31'd0, wb_ready}, 32'd0);
        @(posedge clk);              // not accepted: ready was low
        #1;
        check("b2b.gap_we",    {31'd0, RegWrite}, 32'd0);
        check("b2b.ready_n2",  {31'd0, wb_ready}, 32'd1);
        @(posedge clk);              // accept edge N+2
        #1;
        wb_valid = 1'b0;
        check("b2b.second_we", {31'd0, RegWrite}, 32'd1);
        check("b2b.second_wr", {27'd0, WriteReg}, 32'd8);
        check("b2b.second_mr", {28'd0, MemtoReg}, 32'd4);
        check("b2b.second_dn", {31'd0, wb_done},  32'd1);

        // ---- reset mid-operation drops the pending load ----
        @(negedge clk);
        wb_valid = 1'b1;
        wb_src   = 4'd1;
        wb_dst   = 5'd10;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_memto = 4'd0;
        m_wreg  = 5'd0;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_idle_outputs($sformatf("after_mid_reset_c%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
Write-back sequencer that drives the register-bank write port. It accepts one write-back request at a time (source code plus destination register), waits out memory latency for load sources, then drives the 4-bit MemtoReg select and RegWrite for exactly one cycle. It sits between the control unit and the MemtoReg data mux / register bank.

Parameters:
MEM_WAIT, 2, cycles between request acceptance and load data being valid at mux input 1
MEM_SRC, 4'd1, source code that requires the MEM_WAIT delay
MAX_SRC, 4'd8, highest legal source code

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
wb_valid  in  1  request valid
wb_ready  out  1  block can accept a request
wb_src  in  4  MemtoReg source code
wb_dst  in  5  destination register index
flush  in  1  abort any pending write-back (exception/branch squash)
MemtoReg  out  4  select to MemtoReg mux
RegWrite  out  1  register-bank write enable
WriteReg  out  5  register-bank write address
wb_done  out  1  one-cycle pulse: request retired (written or dropped for $0)
wb_err  out  1  one-cycle pulse: illegal source rejected

Behaviour:
- Reset (clk edge with reset=1): state IDLE; MemtoReg=0, RegWrite=0, WriteReg=0, wb_done=0, wb_err=0, wait counter=0; wb_ready=1 the following cycle. Reset mid-operation drops the pending request with no write.
- Handshake: accept when wb_valid && wb_ready at a rising edge. wb_ready=1 only in IDLE. src/dst latched at acceptance; later input changes ignored.
- States: IDLE, WAIT, WRITE.
- IDLE on accept:
  - src==7 or src>MAX_SRC -> stay IDLE, wb_err=1 for one cycle, no write, no wb_done.
  - src==MEM_SRC -> WAIT, counter loaded with MEM_WAIT-1; MEM_WAIT==0 goes straight to WRITE.
  - otherwise -> WRITE.
- WAIT: counter decrements each cycle; at 0 -> WRITE.
- WRITE (one cycle): RegWrite=1 unless the latched dst==0; wb_done=1; next state IDLE.
- Outputs are registered. MemtoReg and WriteReg take the latched values the cycle after acceptance. They hold through WAIT and WRITE and keep those values in IDLE until the next accept. This guarantees the mux output is stable before RegWrite.
- Latency (accept edge = cycle N): non-memory source -> RegWrite high in cycle N+1. Memory source -> RegWrite high in cycle N+1+MEM_WAIT.
- flush: sampled every edge and has priority over everything except reset.
  - In WAIT or WRITE: go to IDLE, RegWrite=0, no wb_done.
  - In IDLE: blocks acceptance that cycle; wb_valid is ignored.
- Back-to-back: a request can be accepted in the cycle after WRITE (IDLE). Sustained rate for non-memory sources is 1 write per 2 cycles.
- dst==0: full sequence runs and wb_done pulses, but RegWrite stays 0.

Optional Feature:
WB_PENDING_EN
- Defined: adds outputs pend_valid (1) and pend_reg (5).
  - pend_valid=1 from the cycle after acceptance through the WRITE cycle inclusive; cleared by flush/reset.
  - pend_reg = latched dst.
  - Used by the decoder for RAW stalls.
- Undefined: ports absent, no extra logic.

Decomposition:
- Package wb_pkg holds:
  - source code constants: SRC_ALUOUT=0, SRC_MDR=1, SRC_CONST227=2, SRC_3..SRC_6, SRC_RSVD=7, SRC_8
  - state encoding IDLE=2'd0, WAIT=2'd1, WRITE=2'd2
  - function is_legal_src
- One sub-module, wb_wait_cnt: loadable down-counter with a zero flag, instantiated once.

Test Plan:
- Reset with wb_valid=1, src=0 -> no accept; all outputs 0; wb_ready=1 one cycle after reset drops.
- Accept src=0, dst=5 at cycle N -> MemtoReg=0, WriteReg=5 at N+1; RegWrite=1 and wb_done=1 in cycle N+1 only; wb_ready=1 at N+2.
- Accept src=1, dst=9, MEM_WAIT=2 -> MemtoReg=1 from N+1; RegWrite=1 only at N+3.
- Accept src=7, then src=9 -> wb_err pulse each, RegWrite never asserts, wb_ready stays 1.
- Accept src=1, dst=4, assert flush at N+2 -> state IDLE, no RegWrite, no wb_done; next request src=3, dst=6 writes normally.
- Accept src=2, dst=0 -> wb_done pulse with RegWrite=0. With WB_PENDING_EN defined, src=0, dst=12 -> pend_valid=1 and pend_reg=12 for N+1 only.
